// File: rtl/biriscv_fetch_pc_pkg.sv
// Shared fetch definitions: fetch width, slot count, PC-stage state encodings and the buffered entry.
package biriscv_defs;

   localparam int FETCH_WIDTH = 64;
   localparam int SLOT_COUNT  = 2;

   localparam logic [1:0] STATE_RUN  = 2'd0;
   localparam logic [1:0] STATE_WAIT = 2'd1;
   localparam logic [1:0] STATE_HOLD = 2'd2;

   typedef struct packed {
      logic [FETCH_WIDTH-1:0] instr;
      logic [31:0]            pc;
      logic [SLOT_COUNT-1:0]  pred;
      logic                   fault;
   } fetch_entry_t;

   // ICache lines are fetched on 8-byte boundaries.
   function automatic logic [31:0] align_fetch_pc(input logic [31:0] pc);
      return {pc[31:3], 3'b000};
   endfunction

endpackage

// File: rtl/biriscv_fetch_pc_if.sv
// Signal bundle between the fetch PC stage, the predictor, the ICache and decode.
interface biriscv_fetch_pc_if;
   import biriscv_defs::*;

   logic                   branch_request_i;
   logic [31:0]            branch_pc_i;
   logic [31:0]            next_pc_f_i;
   logic [SLOT_COUNT-1:0]  next_taken_f_i;
   logic [31:0]            pc_f_o;
   logic                   pc_accept_o;
   logic                   icache_rd_o;
   logic [31:0]            icache_pc_o;
   logic                   icache_accept_i;
   logic                   icache_valid_i;
   logic                   icache_error_i;
   logic [FETCH_WIDTH-1:0] icache_inst_i;
   logic                   fetch_valid_o;
   logic                   fetch_accept_i;
   logic [FETCH_WIDTH-1:0] fetch_instr_o;
   logic [31:0]            fetch_pc_o;
   logic [SLOT_COUNT-1:0]  fetch_pred_branch_o;
   logic                   fetch_fault_o;

   modport master (
      input  branch_request_i, branch_pc_i, next_pc_f_i, next_taken_f_i,
             icache_accept_i, icache_valid_i, icache_error_i, icache_inst_i,
             fetch_accept_i,
      output pc_f_o, pc_accept_o, icache_rd_o, icache_pc_o,
             fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_pred_branch_o, fetch_fault_o
   );

   modport slave (
      output branch_request_i, branch_pc_i, next_pc_f_i, next_taken_f_i,
             icache_accept_i, icache_valid_i, icache_error_i, icache_inst_i,
             fetch_accept_i,
      input  pc_f_o, pc_accept_o, icache_rd_o, icache_pc_o,
             fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_pred_branch_o, fetch_fault_o
   );

endinterface

// File: rtl/biriscv_fetch_skid.sv
// One-entry skid buffer holding an ICache response while decode is stalled.
module biriscv_fetch_skid
   import biriscv_defs::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         clear_i,
   input  fetch_entry_t entry_i,
   output logic         valid_o,
   output fetch_entry_t entry_o
);

   logic         valid_q;
   fetch_entry_t entry_q;

   // Clear wins over push so a redirect always empties the buffer.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         valid_q <= 1'b0;
         entry_q <= '0;
      end else if (push_i) begin
         valid_q <= 1'b1;
         entry_q <= entry_i;
      end
   end

   assign valid_o = valid_q;
   assign entry_o = entry_q;

endmodule

// File: rtl/biriscv_fetch_pc.sv
// Fetch PC stage: issues one ICache request at a time and buffers responses for decode.
// Optional fault reporting is enabled by defining BIRISCV_FETCH_FAULT_EN.
module biriscv_fetch_pc
   import biriscv_defs::*;
#(
   parameter logic [31:0] RESET_PC = 32'h80000000
)
(
   input  logic                clk_i,
   input  logic                rst_i,
   biriscv_fetch_pc_if.master  bus
);

   logic [1:0]            state_q;
   logic [31:0]           pc_q;
   logic [31:0]           req_pc_q;
   logic [SLOT_COUNT-1:0] req_taken_q;
   logic                  drop_q;

   logic                  fault_w;
   logic                  icache_rd_w;
   logic                  issue_w;
   logic                  resp_keep_w;
   logic                  fetch_valid_w;
   logic                  skid_valid;
   logic                  skid_push;
   logic                  skid_clear;
   fetch_entry_t          skid_entry;
   fetch_entry_t          resp_entry;
   fetch_entry_t          out_entry;

`ifdef BIRISCV_FETCH_FAULT_EN
   assign fault_w = bus.icache_error_i;
`else
   assign fault_w = 1'b0;
`endif

   assign icache_rd_w = !rst_i && (state_q == STATE_RUN) && !bus.branch_request_i && !skid_valid;
   assign issue_w     = icache_rd_w && bus.icache_accept_i;

   // A response is only forwarded if nothing has redirected fetch since it was issued.
   assign resp_keep_w = (state_q == STATE_WAIT) && bus.icache_valid_i && !drop_q && !bus.branch_request_i;

   always_comb begin
      resp_entry       = '0;
      resp_entry.instr = fault_w ? '0 : bus.icache_inst_i;
      resp_entry.pc    = req_pc_q;
      resp_entry.pred  = req_taken_q;
      resp_entry.fault = fault_w;
   end

   assign skid_push  = !rst_i && resp_keep_w && !bus.fetch_accept_i;
   assign skid_clear = bus.branch_request_i || ((state_q == STATE_HOLD) && bus.fetch_accept_i);

   biriscv_fetch_skid u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (skid_push),
      .clear_i (skid_clear),
      .entry_i (resp_entry),
      .valid_o (skid_valid),
      .entry_o (skid_entry)
   );

   assign fetch_valid_w = !rst_i && ((state_q == STATE_HOLD) ? skid_valid : resp_keep_w);
   assign out_entry     = fetch_valid_w ? ((state_q == STATE_HOLD) ? skid_entry : resp_entry) : '0;

   // A redirect that lands while a request is still in flight must wait out and drop that response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q        <= RESET_PC;
         state_q     <= STATE_RUN;
         drop_q      <= 1'b0;
         req_pc_q    <= '0;
         req_taken_q <= '0;
      end else if (bus.branch_request_i) begin
         pc_q <= bus.branch_pc_i;
         if ((state_q == STATE_WAIT) && !bus.icache_valid_i) begin
            state_q <= STATE_WAIT;
            drop_q  <= 1'b1;
         end else begin
            state_q <= STATE_RUN;
            drop_q  <= 1'b0;
         end
      end else begin
         case (state_q)
            STATE_RUN: begin
               if (issue_w) begin
                  pc_q        <= bus.next_pc_f_i;
                  req_pc_q    <= pc_q;
                  req_taken_q <= bus.next_taken_f_i;
                  state_q     <= STATE_WAIT;
               end
            end
            STATE_WAIT: begin
               if (bus.icache_valid_i) begin
                  drop_q <= 1'b0;
                  if (drop_q || bus.fetch_accept_i)
                     state_q <= STATE_RUN;
                  else
                     state_q <= STATE_HOLD;
               end
            end
            STATE_HOLD: begin
               if (bus.fetch_accept_i)
                  state_q <= STATE_RUN;
            end
            default: state_q <= STATE_RUN;
         endcase
      end
   end

   assign bus.pc_f_o              = pc_q;
   assign bus.pc_accept_o         = issue_w;
   assign bus.icache_rd_o         = icache_rd_w;
   assign bus.icache_pc_o         = align_fetch_pc(pc_q);
   assign bus.fetch_valid_o       = fetch_valid_w;
   assign bus.fetch_instr_o       = out_entry.instr;
   assign bus.fetch_pc_o          = out_entry.pc;
   assign bus.fetch_pred_branch_o = out_entry.pred;
   assign bus.fetch_fault_o       = out_entry.fault;

endmodule

// File: tb/tb_biriscv_fetch_pc.sv
// Directed bench for biriscv_fetch_pc with a scoreboard of expected decode deliveries.
module tb_biriscv_fetch_pc;
   import biriscv_defs::*;

   localparam logic [31:0] RESET_PC_TB = 32'h80000000;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   logic [31:0] expPc;
   fetch_entry_t e;
   fetch_entry_t sb[$];

   biriscv_fetch_pc_if bus ();

   biriscv_fetch_pc #(.RESET_PC(RESET_PC_TB)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Waits for the cycle after the next rising edge, drives all inputs, then lets logic settle.
   task automatic applyStimulus(input logic br, input logic [31:0] bpc, input logic [31:0] npc,
                                input logic [1:0] tk, input logic acc, input logic vld,
                                input logic err, input logic [63:0] inst, input logic facc);
      @(posedge clk);
      #1;
      bus.branch_request_i = br;
      bus.branch_pc_i      = bpc;
      bus.next_pc_f_i      = npc;
      bus.next_taken_f_i   = tk;
      bus.icache_accept_i  = acc;
      bus.icache_valid_i   = vld;
      bus.icache_error_i   = err;
      bus.icache_inst_i    = inst;
      bus.fetch_accept_i   = facc;
      #1;
   endtask

   task automatic checkDelivery(input string tag, input bit doPop);
      fetch_entry_t got;
      checkOutput({tag, "_valid"}, bus.fetch_valid_o, 1'b1);
      checkOutput({tag, "_sb"}, (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
         got = '{instr: bus.fetch_instr_o, pc: bus.fetch_pc_o,
                 pred: bus.fetch_pred_branch_o, fault: bus.fetch_fault_o};
         checkOutput({tag, "_entry"}, got, sb[0]);
         if (doPop) void'(sb.pop_front());
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      bus.branch_request_i = 1'b0;
      bus.branch_pc_i      = '0;
      bus.next_pc_f_i      = '0;
      bus.next_taken_f_i   = '0;
      bus.icache_accept_i  = 1'b1;
      bus.icache_valid_i   = 1'b0;
      bus.icache_error_i   = 1'b0;
      bus.icache_inst_i    = '0;
      bus.fetch_accept_i   = 1'b0;

      @(posedge clk);
      #2;
      checkOutput("rst_rd", bus.icache_rd_o, 1'b0);
      checkOutput("rst_acc", bus.pc_accept_o, 1'b0);
      checkOutput("rst_fv", bus.fetch_valid_o, 1'b0);
      checkOutput("rst_instr", bus.fetch_instr_o, 64'h0);
      checkOutput("rst_fpc", bus.fetch_pc_o, 32'h0);
      checkOutput("rst_pred", bus.fetch_pred_branch_o, 2'b00);
      checkOutput("rst_fault", bus.fetch_fault_o, 1'b0);
      checkOutput("rst_pcf", bus.pc_f_o, 32'h80000000);
      checkOutput("rst_icpc", bus.icache_pc_o, 32'h80000000);
      rst = 1'b0;
      bus.icache_accept_i = 1'b0;

      // Streaming fetch with single-cycle ICache latency and decode always accepting.
      expPc = RESET_PC_TB;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, expPc + 32'd8, 2'(i), 1, 0, 0, 64'h0, 1);
         checkOutput("run_rd", bus.icache_rd_o, 1'b1);
         checkOutput("run_icpc", bus.icache_pc_o, expPc);
         checkOutput("run_acc", bus.pc_accept_o, 1'b1);
         checkOutput("run_fv", bus.fetch_valid_o, 1'b0);
         applyStimulus(0, 0, 0, 0, 1, 1, 0, {32'hA0000000 + 32'(i), 32'hB0000000 + 32'(i)}, 1);
         sb.push_back('{instr: {32'hA0000000 + 32'(i), 32'hB0000000 + 32'(i)}, pc: expPc, pred: 2'(i), fault: 1'b0});
         checkOutput("wait_rd", bus.icache_rd_o, 1'b0);
         checkDelivery("stream", 1);
         expPc = expPc + 32'd8;
      end

      // Decode stalls on a response: it is held, stable, and delivered exactly once.
      applyStimulus(0, 0, expPc + 32'd8, 2'b10, 1, 0, 0, 64'h0, 0);
      checkOutput("hold_issue_pc", bus.icache_pc_o, 32'h80000018);
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 64'h1122334455667788, 0);
      sb.push_back('{instr: 64'h1122334455667788, pc: 32'h80000018, pred: 2'b10, fault: 1'b0});
      checkDelivery("hold_pass", 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 0, 0, 64'hDEADBEEFDEADBEEF, 0);
         checkOutput("hold_rd", bus.icache_rd_o, 1'b0);
         checkOutput("hold_acc", bus.pc_accept_o, 1'b0);
         checkDelivery("hold_stable", 0);
      end
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 64'h0, 1);
      checkDelivery("hold_accept", 1);

      // Redirect while a request is outstanding drops the in-flight response.
      applyStimulus(0, 0, 32'h80000028, 0, 1, 0, 0, 64'h0, 1);
      checkOutput("after_hold_fv", bus.fetch_valid_o, 1'b0);
      checkOutput("after_hold_icpc", bus.icache_pc_o, 32'h80000020);
      checkOutput("after_hold_acc", bus.pc_accept_o, 1'b1);
      applyStimulus(1, 32'h80001004, 0, 0, 0, 0, 0, 64'h0, 1);
      checkOutput("redir_rd", bus.icache_rd_o, 1'b0);
      checkOutput("redir_fv", bus.fetch_valid_o, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 64'h5555555555555555, 1);
      checkOutput("drop_fv", bus.fetch_valid_o, 1'b0);
      applyStimulus(0, 0, 32'h80001008, 2'b01, 1, 0, 0, 64'h0, 1);
      checkOutput("redir_icpc", bus.icache_pc_o, 32'h80001000);
      checkOutput("redir_pcf", bus.pc_f_o, 32'h80001004);
      checkOutput("redir_acc", bus.pc_accept_o, 1'b1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 64'h0123456789ABCDEF, 1);
      sb.push_back('{instr: 64'h0123456789ABCDEF, pc: 32'h80001004, pred: 2'b01, fault: 1'b0});
      checkDelivery("redir_deliver", 1);

      // Redirect coinciding with a response, then with a possible issue.
      applyStimulus(0, 0, 32'h80001010, 0, 1, 0, 0, 64'h0, 1);
      checkOutput("coin_issue_icpc", bus.icache_pc_o, 32'h80001008);
      applyStimulus(1, 32'h80002000, 0, 0, 0, 1, 0, 64'h7777777777777777, 1);
      checkOutput("coin_fv", bus.fetch_valid_o, 1'b0);
      applyStimulus(1, 32'hFFFFFFF8, 32'h12345678, 0, 1, 0, 0, 64'h0, 1);
      checkOutput("coin_run_icpc", bus.icache_pc_o, 32'h80002000);
      checkOutput("coin_run_rd", bus.icache_rd_o, 1'b0);
      checkOutput("coin_run_acc", bus.pc_accept_o, 1'b0);

      // Address wrap from the top of the address space.
      applyStimulus(0, 0, 32'h00000000, 2'b11, 1, 0, 0, 64'h0, 1);
      checkOutput("wrap_icpc_top", bus.icache_pc_o, 32'hFFFFFFF8);
      checkOutput("wrap_acc", bus.pc_accept_o, 1'b1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 64'hCAFEF00DCAFEF00D, 1);
      sb.push_back('{instr: 64'hCAFEF00DCAFEF00D, pc: 32'hFFFFFFF8, pred: 2'b11, fault: 1'b0});
      checkDelivery("wrap_deliver", 1);
      applyStimulus(0, 0, 32'h00000008, 0, 1, 0, 0, 64'h0, 1);
      checkOutput("wrap_icpc_zero", bus.icache_pc_o, 32'h00000000);
      checkOutput("wrap_pcf_zero", bus.pc_f_o, 32'h00000000);

      // Errored response.
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 64'h0BADC0DE0BADC0DE, 1);
`ifdef BIRISCV_FETCH_FAULT_EN
      sb.push_back('{instr: 64'h0, pc: 32'h00000000, pred: 2'b00, fault: 1'b1});
      checkOutput("fault_flag", bus.fetch_fault_o, 1'b1);
`else
      sb.push_back('{instr: 64'h0BADC0DE0BADC0DE, pc: 32'h00000000, pred: 2'b00, fault: 1'b0});
      checkOutput("fault_flag", bus.fetch_fault_o, 1'b0);
`endif
      checkDelivery("fault_deliver", 1);

      // Unsolicited response, then reset abandoning an outstanding request.
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 64'h9999999999999999, 1);
      checkOutput("unsol_fv", bus.fetch_valid_o, 1'b0);
      checkOutput("unsol_icpc", bus.icache_pc_o, 32'h00000008);
      applyStimulus(0, 0, 32'h00000010, 0, 1, 0, 0, 64'h0, 1);
      checkOutput("pre_rst_acc", bus.pc_accept_o, 1'b1);
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 64'h0, 1);
      checkOutput("mid_rst_pcf", bus.pc_f_o, 32'h80000000);
      checkOutput("mid_rst_rd", bus.icache_rd_o, 1'b0);
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 64'h4444444444444444, 1);
      checkOutput("late_fv", bus.fetch_valid_o, 1'b0);
      checkOutput("late_rd", bus.icache_rd_o, 1'b1);
      checkOutput("late_icpc", bus.icache_pc_o, 32'h80000000);

      checkOutput("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/biriscv_fetch_pc.md
BIRISCV_FETCH_PC -- requirements
Module: biriscv_fetch_pc

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h80000000, the PC fetched first after reset.
REQ-002 The block SHALL have port clk_i  in  1  clock, all logic on its rising edge.
REQ-003 The block SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port branch_request_i  in  1  redirect from execute/commit.
REQ-005 The block SHALL have port branch_pc_i  in  32  redirect target.
REQ-006 The block SHALL have port next_pc_f_i  in  32  predicted next PC from the next-PC predictor.
REQ-007 The block SHALL have port next_taken_f_i  in  2  predicted-taken slot mask for pc_f_o.
REQ-008 The block SHALL have port pc_f_o  out  32  current fetch PC to the predictor.
REQ-009 The block SHALL have port pc_accept_o  out  1  fetch PC issued this cycle.
REQ-010 The block SHALL have ports icache_rd_o out 1, icache_pc_o out 32 (8-byte aligned) and icache_accept_i in 1 for the request.
REQ-011 The block SHALL have ports icache_valid_i in 1, icache_error_i in 1 and icache_inst_i in 64 for the response.
REQ-012 The block SHALL have ports fetch_valid_o out 1, fetch_accept_i in 1, fetch_instr_o out 64, fetch_pc_o out 32, fetch_pred_branch_o out 2 and fetch_fault_o out 1 toward decode.

Function
REQ-013 The block SHALL allow at most one outstanding ICache request.
REQ-014 The block SHALL use states RUN (may issue), WAIT (request outstanding) and HOLD (response buffered, decode stalled).
REQ-015 In RUN, icache_rd_o SHALL be 1 unless branch_request_i=1 or the skid buffer is full; icache_pc_o = {pc_f_o[31:3],3'b0}.
REQ-016 Issue SHALL occur when icache_rd_o & icache_accept_i; that cycle pc_accept_o=1, pc_q<=next_pc_f_i, and the issued PC and next_taken_f_i are captured; state goes to WAIT.
REQ-017 In WAIT, an icache_valid_i response SHALL be presented to decode in the same cycle (fetch_valid_o=1, pass-through), with the captured PC and mask.
REQ-018 If fetch_accept_i=1 with the response, the block SHALL return to RUN; otherwise the response SHALL be stored in the one-entry skid buffer and the state SHALL go to HOLD.
REQ-019 In HOLD, fetch_valid_o SHALL be 1 from the buffer; on fetch_accept_i the buffer SHALL clear and the state SHALL go to RUN the next cycle.
REQ-020 branch_request_i SHALL set pc_q<=branch_pc_i, clear the skid buffer, and mark any outstanding response for drop; the state SHALL go to WAIT-drop if a request is outstanding, otherwise to RUN.
REQ-021 A dropped response SHALL never assert fetch_valid_o, and its arrival SHALL return the state to RUN.
REQ-022 When branch_request_i and icache_valid_i coincide, the response SHALL be dropped.
REQ-023 When a redirect coincides with a possible issue, no issue SHALL occur; the next cycle SHALL issue branch_pc_i.
REQ-024 If branch_pc_i[2]=1, fetch_pc_o[2] SHALL be 1; decode discards slot 0.
REQ-025 fetch_pred_branch_o SHALL equal the next_taken_f_i captured at issue.
REQ-026 PC arithmetic SHALL be modulo 2^32; 32'hFFFFFFF8 followed by 32'h00000000 is legal.
REQ-027 An icache_valid_i that arrives with no request outstanding SHALL be ignored.

Reset
REQ-028 On rst_i: pc_q=RESET_PC, state=RUN, skid buffer empty, drop flag 0, and all outputs 0 except pc_f_o=RESET_PC and icache_pc_o={RESET_PC[31:3],3'b0}.
REQ-029 Reset asserted mid-request SHALL abandon the request; a late response SHALL be ignored per REQ-027.

Configuration
REQ-030 The macro BIRISCV_FETCH_FAULT_EN SHALL control fault reporting.
- Defined: icache_error_i is carried with the response to fetch_fault_o; fetch_instr_o is forced to 0 when faulting.
- Undefined: fetch_fault_o is tied 0, icache_error_i is ignored and the data is passed as normal.

Structure
REQ-031 The fetch width (64), the instruction-slot count (2) and the state encodings SHALL live in the shared package biriscv_defs.
REQ-032 The skid buffer (data, PC, mask, fault, valid) SHALL be the sub-module biriscv_fetch_skid.

Verification
REQ-033 The bench SHALL cover: reset, accept=1, 1-cycle ICache latency -> icache_pc_o sequence 80000000, 80000008, 80000010; fetch_valid_o every other cycle.
REQ-034 The bench SHALL cover: response with fetch_accept_i=0 for 3 cycles -> HOLD; no icache_rd_o; data is stable and delivered once on accept.
REQ-035 The bench SHALL cover: branch_request_i to 80001004 while WAIT -> the in-flight response is dropped; next icache_pc_o=80001000; fetch_pc_o=80001004.
REQ-036 The bench SHALL cover: branch_request_i coincident with icache_valid_i -> no fetch_valid_o that cycle.
REQ-037 The bench SHALL cover: next_pc_f_i=00000000 from pc FFFFFFF8 -> icache_pc_o wraps to 00000000.
REQ-038 The bench SHALL cover: icache_error_i=1 -> with BIRISCV_FETCH_FAULT_EN, fetch_fault_o=1 and fetch_instr_o=0; without it, fetch_fault_o=0.
